rect_to_cyl_sched: RTL and testbench

Round-robin scheduler that shares one `rect_to_cyl` conversion core between `NREQ` requesters. Each requester presents signed 8-bit (x, y, z) operands with a valid/ready handshake. The scheduler latches the winner's operands, pulses the core's `start`, and waits for `done`, bounded by a watchdog. It then returns `r`/`theta`/`z_out` tagged with the requester id on a single response channel. It sits between the requester ports and the core instance, inside the top-level wrapper.

---
 rtl/rect_to_cyl_sched.sv | 142 ++++++++++++++
 tb/tb_rect_to_cyl_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rect_to_cyl_sched.sv
// Round-robin scheduler sharing one rect_to_cyl core between NREQ requesters,
// with a watchdog on core completion and a single tagged response channel.
module rect_to_cyl_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(NREQ),
  localparam int CW     = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  input  logic [8*NREQ-1:0] req_z,
  output logic [NREQ-1:0]   req_ready,
  output logic              core_start,
  output logic [7:0]        core_x,
  output logic [7:0]        core_y,
  output logic [7:0]        core_z,
  input  logic              core_done,
  input  logic [7:0]        core_r,
  input  logic [7:0]        core_theta,
  input  logic [7:0]        core_z_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_r,
  output logic [7:0]        rsp_theta,
  output logic [7:0]        rsp_z,
  output logic              rsp_timeout,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;

  logic [IDW-1:0] ptr_q, gid_q, winner, ptr_nxt;
  logic [CW-1:0]  cnt_q;
  logic [7:0]     cx_q, cy_q, cz_q, r_q, th_q, z_q;
  logic           to_q, found, at_limit;

  // Rotating priority search starting at ptr_q
  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx  = (32'(ptr_q) + k) % NREQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign ptr_nxt  = (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
  assign at_limit = (cnt_q == CW'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (core_done || at_limit) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (found && !rst) req_ready = {{(NREQ-1){1'b0}}, 1'b1} << winner;
      S_ISSUE: core_start = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      gid_q <= '0;
      cnt_q <= '0;
      cx_q  <= '0;
      cy_q  <= '0;
      cz_q  <= '0;
      r_q   <= '0;
      th_q  <= '0;
      z_q   <= '0;
      to_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (found) begin
          cx_q  <= req_x[8*winner +: 8];
          cy_q  <= req_y[8*winner +: 8];
          cz_q  <= req_z[8*winner +: 8];
          gid_q <= winner;
          ptr_q <= ptr_nxt;
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          // done takes precedence over the watchdog limit in the same cycle
          if (core_done) begin
            r_q  <= core_r;
            th_q <= core_theta;
            z_q  <= core_z_out;
            to_q <= 1'b0;
          end else if (at_limit) begin
            r_q  <= '0;
            th_q <= '0;
            z_q  <= '0;
            to_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_x      = cx_q;
  assign core_y      = cy_q;
  assign core_z      = cz_q;
  assign rsp_id      = gid_q;
  assign rsp_r       = r_q;
  assign rsp_theta   = th_q;
  assign rsp_z       = z_q;
  assign rsp_timeout = to_q;

endmodule

// File: tb/tb_rect_to_cyl_sched.sv
// Directed bench for rect_to_cyl_sched: single request, round-robin, pointer
// skip, backpressure, watchdog (both outcomes) and mid-operation reset.
module tb_rect_to_cyl_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_x, req_y, req_z;
  logic [3:0]  req_ready;
  logic        core_start;
  logic [7:0]  core_x, core_y, core_z;
  logic        core_done;
  logic [7:0]  core_r, core_theta, core_z_out;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_r, rsp_theta, rsp_z;
  logic        rsp_timeout, busy;

  int total = 0;
  int bad   = 0;

  rect_to_cyl_sched #(.NREQ(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .req_ready(req_ready),
    .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_done(core_done), .core_r(core_r), .core_theta(core_theta),
    .core_z_out(core_z_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_theta(rsp_theta), .rsp_z(rsp_z),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] sr, st, sz;
    int n;

    rst = 1'b1; req_valid = 4'b0001; rsp_ready = 1'b1;
    req_x = '0; req_y = '0; req_z = '0;
    core_done = 1'b0; core_r = '0; core_theta = '0; core_z_out = '0;
    tick(); tick();
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(core_start), 0);
    chk("rst_rvalid", 32'(rsp_valid), 0);
    chk("rst_cx", 32'(core_x), 0);
    chk("rst_rid", 32'(rsp_id), 0);
    chk("rst_rto", 32'(rsp_timeout), 0);
    req_valid = 4'b0000; rst = 1'b0;
    tick();

    // Single request, core done 5 cycles after start
    req_x[7:0] = 8'd3; req_y[7:0] = 8'd4; req_z[7:0] = 8'hFE;
    req_valid = 4'b0001;
    #1 chk("s_ready_T", 32'(req_ready), 32'h1);
    tick(); req_valid = 4'b0000; #1;
    chk("s_start_T1", 32'(core_start), 1);
    chk("s_cx", 32'(core_x), 3);
    chk("s_cy", 32'(core_y), 4);
    chk("s_cz", 32'(core_z), 32'hFE);
    tick();
    chk("s_start_T2", 32'(core_start), 0);
    tick(); tick(); tick(); tick();
    core_done = 1'b1; core_r = 8'd5; core_theta = 8'h25; core_z_out = 8'hFE;
    chk("s_rvalid_T6", 32'(rsp_valid), 0);
    tick(); core_done = 1'b0; #1;
    chk("s_rvalid_T7", 32'(rsp_valid), 1);
    chk("s_rid", 32'(rsp_id), 0);
    chk("s_rr", 32'(rsp_r), 5);
    chk("s_rth", 32'(rsp_theta), 32'h25);
    chk("s_rz", 32'(rsp_z), 32'hFE);
    chk("s_rto", 32'(rsp_timeout), 0);
    tick();
    chk("s_idle_busy", 32'(busy), 0);

    // Round-robin from a fresh pointer, 1-cycle core
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      req_x[8*i +: 8] = 8'(16*i + 1);
      req_y[8*i +: 8] = 8'(16*i + 2);
      req_z[8*i +: 8] = 8'(16*i + 3);
    end
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1 << (g % 4)));
      tick();
      chk("rr_start", 32'(core_start), 1);
      chk("rr_cx", 32'(core_x), 16*(g % 4) + 1);
      tick();
      core_done = 1'b1;
      core_r = core_x + 8'd1; core_theta = core_y; core_z_out = core_z;
      tick(); core_done = 1'b0; #1;
      chk("rr_rvalid", 32'(rsp_valid), 1);
      chk("rr_rid", 32'(rsp_id), g % 4);
      chk("rr_rr", 32'(rsp_r), 16*(g % 4) + 2);
      chk("rr_rth", 32'(rsp_theta), 16*(g % 4) + 2);
      chk("rr_rz", 32'(rsp_z), 16*(g % 4) + 3);
      tick();
    end
    req_valid = 4'b0000;

    // Pointer skip: grant 2, then 0011 must go to 0
    tick();
    req_valid = 4'b0100;
    #1 chk("ps_ready2", 32'(req_ready), 32'h4);
    tick(); req_valid = 4'b0000;
    tick(); core_done = 1'b1;
    tick(); core_done = 1'b0;
    tick();
    req_valid = 4'b0011; rsp_ready = 1'b0;
    #1 chk("ps_ready0", 32'(req_ready), 32'h1);

    // Backpressure on that transaction
    tick();
    tick(); core_done = 1'b1; core_r = 8'h11; core_theta = 8'h22; core_z_out = 8'h33;
    tick(); core_done = 1'b0;
    sr = rsp_r; st = rsp_theta; sz = rsp_z;
    chk("bp_captured", 32'({sr, st, sz}), 32'h112233);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_rvalid", 32'(rsp_valid), 1);
      chk("bp_hold", 32'({rsp_id, rsp_r, rsp_theta, rsp_z}), {8'h0, 8'h11, 8'h22, 8'h33});
      chk("bp_noready", 32'(req_ready), 0);
      chk("bp_nostart", 32'(core_start), 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle", 32'(busy), 0);
    chk("bp_nextready", 32'(req_ready), 32'h2);
    req_valid = 4'b0000;

    // Watchdog expiry: requester 1, no done
    req_valid = 4'b0010;
    #1 chk("wd_ready", 32'(req_ready), 32'h2);
    n = 0;
    tick(); req_valid = 4'b0000; n++;
    while (!rsp_valid && n < 200) begin
      tick(); n++;
    end
    chk("wd_latency", n, 66);
    chk("wd_rto", 32'(rsp_timeout), 1);
    chk("wd_rid", 32'(rsp_id), 1);
    chk("wd_data", 32'({rsp_r, rsp_theta, rsp_z}), 0);
    tick();

    // done coincides with the watchdog limit: done wins
    req_valid = 4'b0100;
    #1 chk("wc_ready", 32'(req_ready), 32'h4);
    for (int c = 1; c <= 65; c++) begin
      tick();
      if (c == 1) req_valid = 4'b0000;
    end
    core_done = 1'b1; core_r = 8'h7A; core_theta = 8'h81; core_z_out = 8'h9C;
    chk("wc_rvalid_65", 32'(rsp_valid), 0);
    tick(); core_done = 1'b0;
    chk("wc_rvalid_66", 32'(rsp_valid), 1);
    chk("wc_rto", 32'(rsp_timeout), 0);
    chk("wc_data", 32'({rsp_r, rsp_theta, rsp_z}), 32'h7A819C);
    tick();

    // Mid-operation reset while in WAIT
    req_valid = 4'b1000;
    #1 chk("mr_ready", 32'(req_ready), 32'h8);
    tick(); req_valid = 4'b0000;
    tick(); tick();
    chk("mr_inwait", 32'(busy), 1);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_outs", 32'({req_ready, core_start, rsp_valid, rsp_timeout, rsp_id}), 0);
    chk("mr_core", 32'({core_x, core_y, core_z}), 0);
    chk("mr_rsp", 32'({rsp_r, rsp_theta, rsp_z}), 0);
    core_done = 1'b1; core_r = 8'h55;
    tick(); tick(); core_done = 1'b0;
    chk("mr_late_done", 32'({rsp_valid, busy}), 0);
    chk("mr_late_data", 32'(rsp_r), 0);
    req_valid = 4'b1111;
    #1 chk("mr_first_grant", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
